// File: rtl/finv_sched_if.sv
// finv_sched_if: requester-side bundle of the shared reciprocal scheduler (requests in, results out).
interface finv_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_x;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_y;
    logic [IDW-1:0]     rsp_id;
    modport master (output req_valid, req_x, input req_ready, rsp_valid, rsp_y, rsp_id);
    modport slave  (input req_valid, req_x, output req_ready, rsp_valid, rsp_y, rsp_id);
endinterface

// File: rtl/finv_sched.sv
// finv_sched: round-robin sharing of one fixed-latency finv among NREQ requesters, with id tags and outstanding counts.
module finv_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 3,
    parameter int CNTW = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    finv_sched_if.slave          rq,
    output logic [31:0]          fu_x,
    input  logic [31:0]          fu_y,
    output logic [NREQ*CNTW-1:0] outstanding,
    output logic                 busy
);
    logic [IDW-1:0]  ptr, gid, idx, nxt;
    logic            gnt;
    logic [NREQ-1:0] elig;
    logic [CNTW-1:0] cnt [NREQ];
    logic [LAT:0]    tv;
    logic [IDW-1:0]  tid [LAT+1];
    // Scan downwards so the candidate closest to ptr is the last to win.
    always_comb begin
        gnt = 1'b0;
        gid = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (elig[idx]) begin
                gnt = 1'b1;
                gid = idx;
            end
        end
        nxt = IDW'((int'(gid) + 1) % NREQ);
    end
    assign rq.req_ready = gnt ? NREQ'(1) << gid : '0;
    assign rq.rsp_valid = tv[LAT] ? NREQ'(1) << tid[LAT] : '0;
    assign rq.rsp_id    = tid[LAT];
    assign rq.rsp_y     = fu_y;
    assign busy         = |tv;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
            fu_x <= '0;
            tv <= '0;
            for (int k = 0; k <= LAT; k++) tid[k] <= '0;
        end else begin
            ptr <= gnt ? nxt : ptr;
            fu_x <= gnt ? rq.req_x[32*int'(gid) +: 32] : '0;
            tv <= {tv[LAT-1:0], gnt};
            tid[0] <= gid;
            for (int k = 1; k <= LAT; k++) tid[k] <= tid[k-1];
        end
    end
    genvar i;
    generate
        for (i = 0; i < NREQ; i++) begin : g_cnt
            logic inc, dec;
            assign elig[i] = rstn & rq.req_valid[i] & (cnt[i] != '1);
            assign inc = gnt && (gid == IDW'(i));
            assign dec = rq.rsp_valid[i];
            assign outstanding[i*CNTW +: CNTW] = cnt[i];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) cnt[i] <= '0;
                else if (inc && !dec) cnt[i] <= cnt[i] + 1'b1;
                else if (dec && !inc) cnt[i] <= cnt[i] - 1'b1;
            end
        end
    endgenerate
endmodule

// File: tb/tb_finv_sched.sv
// tb_finv_sched: directed checks of arbitration, tag latency, counters and reset against a stub finv.
module tb_finv_sched;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    finv_sched_if #(.NREQ(4), .IDW(2)) a ();
    finv_sched_if #(.NREQ(4), .IDW(2)) b ();
    logic [31:0] fx0, fy0, fx1, fy1, p0a, p0b, p1a, p1b;
    logic [11:0] o0;
    logic [3:0]  o1;
    logic        bz0, bz1;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] lx [4] = '{32'h4080_0000, 32'h4100_0000, 32'h4000_0000, 32'h3E80_0000};
    finv_sched u0 (.clk(clk), .rstn(rstn), .rq(a.slave), .fu_x(fx0), .fu_y(fy0), .outstanding(o0), .busy(bz0));
    finv_sched #(.CNTW(1)) u1 (.clk(clk), .rstn(rstn), .rq(b.slave), .fu_x(fx1), .fu_y(fy1), .outstanding(o1), .busy(bz1));
    // Stub finv: exact reciprocal for powers of two, three register stages, no reset.
    function automatic logic [31:0] rcp(input logic [31:0] x);
        return {x[31], 8'd254 - x[30:23], 23'd0};
    endfunction
    always_ff @(posedge clk) begin
        p0a <= rcp(fx0);
        p0b <= p0a;
        fy0 <= p0b;
        p1a <= rcp(fx1);
        p1b <= p1a;
        fy1 <= p1b;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input logic [3:0] va, input logic [3:0] vb);
        @(negedge clk);
        a.req_valid = va;
        b.req_valid = vb;
        #1;
    endtask
    initial begin
        a.req_valid = '0;
        b.req_valid = '0;
        a.req_x = {lx[3], lx[2], lx[1], lx[0]};
        b.req_x = {lx[3], lx[2], lx[1], lx[0]};
        cyc(4'hF, 4'hF);
        chk("rst_ready", 32'(a.req_ready), 0);
        chk("rst_ready_b", 32'(b.req_ready), 0);
        chk("rst_rspv", 32'(a.rsp_valid), 0);
        chk("rst_id", 32'(a.rsp_id), 0);
        chk("rst_busy", 32'(bz0), 0);
        chk("rst_fux", fx0, 0);
        chk("rst_out", 32'(o0), 0);
        cyc(4'h0, 4'h0);
        rstn = 1'b1;
        cyc(4'b0100, 4'h0);
        chk("single_ready", 32'(a.req_ready), 32'b0100);
        cyc(4'h0, 4'h0);
        chk("single_fux", fx0, 32'h4000_0000);
        chk("single_busy1", 32'(bz0), 1);
        chk("single_out", 32'(o0), 32'h040);
        cyc(4'h0, 4'h0);
        chk("single_busy2", 32'(bz0), 1);
        cyc(4'h0, 4'h0);
        chk("single_busy3", 32'(bz0), 1);
        chk("single_norsp", 32'(a.rsp_valid), 0);
        cyc(4'h0, 4'h0);
        chk("single_rspv", 32'(a.rsp_valid), 32'b0100);
        chk("single_id", 32'(a.rsp_id), 2);
        chk("single_y", a.rsp_y, 32'h3F00_0000);
        chk("single_busy4", 32'(bz0), 1);
        cyc(4'h0, 4'h0);
        chk("single_idle_busy", 32'(bz0), 0);
        chk("single_idle_out", 32'(o0), 0);
        chk("single_idle_rspv", 32'(a.rsp_valid), 0);
        cyc(4'b1001, 4'h0);
        chk("wrap_g3", 32'(a.req_ready), 32'b1000);
        cyc(4'b0001, 4'h0);
        chk("wrap_g0", 32'(a.req_ready), 32'b0001);
        cyc(4'b0101, 4'h0);
        chk("wrap_ptr1", 32'(a.req_ready), 32'b0100);
        cyc(4'h0, 4'h0);
        chk("wrap_fux", fx0, lx[2]);
        cyc(4'h0, 4'h0);
        chk("wrap_rsp3", 32'(a.rsp_valid), 32'b1000);
        chk("wrap_id3", 32'(a.rsp_id), 3);
        chk("wrap_y3", a.rsp_y, rcp(lx[3]));
        cyc(4'h0, 4'h0);
        chk("wrap_rsp0", 32'(a.rsp_valid), 32'b0001);
        chk("wrap_y0", a.rsp_y, rcp(lx[0]));
        cyc(4'h0, 4'h0);
        chk("wrap_rsp2", 32'(a.rsp_valid), 32'b0100);
        cyc(4'h0, 4'h0);
        chk("wrap_done", 32'(bz0), 0);
        for (int k = 0; k < 10; k++) begin
            cyc(4'h0, 4'h0);
            chk("idle_ready", 32'(a.req_ready), 0);
            chk("idle_fux", fx0, 0);
            chk("idle_rspv", 32'(a.rsp_valid), 0);
            chk("idle_busy", 32'(bz0), 0);
        end
        cyc(4'b1001, 4'h0);
        chk("idle_ptr_held", 32'(a.req_ready), 32'b1000);
        for (int k = 0; k < 5; k++) cyc(4'h0, 4'h0);
        for (int k = 0; k < 12; k++) begin
            cyc(k < 8 ? 4'hF : 4'h0, 4'h0);
            if (k < 8) chk("all_grant", 32'(a.req_ready), 32'(1 << (k % 4)));
            if (k >= 4) begin
                chk("all_rspv", 32'(a.rsp_valid), 32'(1 << (k % 4)));
                chk("all_id", 32'(a.rsp_id), 32'(k % 4));
                chk("all_y", a.rsp_y, rcp(lx[k % 4]));
            end
            if (k == 3) chk("all_out3", 32'(o0), 32'h049);
            chk("all_outmax", 32'(o0[2:0] <= 2 && o0[5:3] <= 2 && o0[8:6] <= 2 && o0[11:9] <= 2), 1);
        end
        cyc(4'h0, 4'h0);
        chk("all_done", 32'(bz0), 0);
        for (int k = 0; k < 11; k++) begin
            cyc(4'h0, 4'b0010);
            chk("lim_ready", 32'(b.req_ready), (k % 5 == 0) ? 32'b0010 : 0);
            chk("lim_rspv", 32'(b.rsp_valid), (k == 4 || k == 9) ? 32'b0010 : 0);
            chk("lim_out", 32'(o1), (k % 5 != 0) ? 32'b0010 : 0);
        end
        for (int k = 0; k < 6; k++) cyc(4'h0, 4'h0);
        chk("lim_done", 32'(bz1), 0);
        cyc(4'b0111, 4'h0);
        chk("mid_g0", 32'(a.req_ready), 32'b0001);
        cyc(4'b0111, 4'h0);
        chk("mid_g1", 32'(a.req_ready), 32'b0010);
        cyc(4'b0111, 4'h0);
        chk("mid_g2", 32'(a.req_ready), 32'b0100);
        cyc(4'h0, 4'h0);
        chk("mid_out", 32'(o0), 32'h049);
        chk("mid_busy", 32'(bz0), 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_out", 32'(o0), 0);
        chk("mid_rst_busy", 32'(bz0), 0);
        chk("mid_rst_rspv", 32'(a.rsp_valid), 0);
        chk("mid_rst_fux", fx0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(4'h0, 4'h0);
            if (k == 0) rstn = 1'b1;
            #1;
            chk("mid_no_rsp", 32'(a.rsp_valid), 0);
            chk("mid_no_busy", 32'(bz0), 0);
        end
        cyc(4'b1100, 4'h0);
        chk("mid_ptr0", 32'(a.req_ready), 32'b0100);
        for (int k = 0; k < 3; k++) cyc(4'h0, 4'h0);
        cyc(4'h0, 4'h0);
        chk("mid_rspv", 32'(a.rsp_valid), 32'b0100);
        chk("mid_id", 32'(a.rsp_id), 2);
        cyc(4'h0, 4'h0);
        chk("mid_done", 32'(bz0), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
